cond_flag_unit: RTL and testbench
=================================

Name: cond_flag_unit

Overview:
- Consumer end of the comparator interface.
- Latches the one-hot EQ/LT/GT result from comparator_8bit into a condition-flag register when the datapath strobes CMP_VALID.
- Resolves branch-condition requests from the control unit through a REQ/ACK handshake.
- Sits between the ALU compare path and the branch/PC-select logic; stalls a branch whose flags are still pending, and times it out.

Parameters:
- TIMEOUT, 15: max cycles a branch waits in WAIT_FLAGS before forced not-taken; 0 = wait forever
- CW, 3: branch condition code width (fixed encoding, not for override)

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- CMP_VALID  in  1  EQ/LT/GT valid this cycle
- EQ  in  1  comparator equal flag
- LT  in  1  comparator less-than flag
- GT  in  1  comparator greater-than flag
- CLR_FLAGS  in  1  invalidate stored flags
- BR_REQ  in  1  branch evaluation request, level, held until BR_ACK
- BR_COND  in  3  condition code, sampled on acceptance
- BR_ACK  out  1  one-cycle response pulse
- BR_TAKEN  out  1  branch decision, valid while BR_ACK=1, else 0
- FLAGS  out  3  stored {GT,LT,EQ}
- FLAGS_VALID  out  1  stored flags usable
- TIMED_OUT  out  1  high with BR_ACK when the response was forced by timeout
- ERR  out  1  sticky: a non-one-hot flag set arrived with CMP_VALID

Behaviour:
- Reset (async, RST=1): all outputs 0; FLAGS=3'b000; state=IDLE; timeout counter=0.
- Condition codes:
  - 000 ALWAYS, 001 EQ, 010 NE, 011 LT
  - 100 GE (GT|EQ), 101 GT, 110 LE (LT|EQ), 111 NEVER
- Flag capture, on a CLK edge with CMP_VALID=1:
  - If {GT,LT,EQ} is one-hot: FLAGS<=inputs, FLAGS_VALID<=1.
  - Otherwise: FLAGS and FLAGS_VALID unchanged, ERR<=1. ERR clears only on RST.
- CLR_FLAGS=1 clears FLAGS_VALID; FLAGS keeps its value. CMP_VALID with legal flags in the same cycle wins: FLAGS_VALID=1.
- Flag-independent codes: ALWAYS and NEVER never wait for flags.
- State IDLE:
  - BR_REQ=1 accepts and samples BR_COND.
  - Flags are usable if the code is flag-independent, or FLAGS_VALID=1, or a legal CMP_VALID is present this cycle. Same-cycle CMP_VALID forwards: the incoming flags are used, not the stored ones.
  - Flags usable -> RESP, with BR_TAKEN computed and registered.
  - Flags not usable -> WAIT_FLAGS, counter<=0.
- State WAIT_FLAGS:
  - Legal CMP_VALID -> RESP, evaluated on the incoming flags.
  - Else, if TIMEOUT!=0 and counter==TIMEOUT-1 -> RESP with BR_TAKEN=0 and TIMED_OUT=1.
  - Else counter++.
  - Illegal CMP_VALID does not release the wait.
  - CLR_FLAGS has no effect on this state.
- State RESP:
  - BR_ACK=1 for exactly this one cycle; BR_TAKEN and TIMED_OUT are valid only here.
  - BR_REQ is ignored this cycle; the requester drops it on the next edge.
  - Next state IDLE unconditionally.
- Latency: 1 cycle from acceptance to BR_ACK when flags are usable. Back-to-back requests are accepted at most every 2 cycles.
- BR_COND changes while waiting are ignored; the sampled code is used.
- Reset mid-handshake: returns to IDLE with BR_ACK=0 immediately (async); the pending request is dropped, not answered.
- Counter width: $clog2(TIMEOUT+1), minimum 1; it saturates and never wraps.

Decomposition:
- Shared package holds:
  - condition-code localparams COND_ALWAYS..COND_NEVER
  - state encoding IDLE=2'd0, WAIT_FLAGS=2'd1, RESP=2'd2
  - flag bit indices FLAG_EQ=0, FLAG_LT=1, FLAG_GT=2
- One natural sub-module: cond_eval. Purely combinational, (flags[2:0], cond[2:0]) -> taken. It is instantiated once and fed by a forward mux that selects incoming or stored flags.

Test Plan:
- RST pulse mid-cycle -> all outputs 0 asynchronously; then CMP_VALID with EQ=1 -> FLAGS=3'b001, FLAGS_VALID=1 on next edge.
- Flags LT stored; BR_REQ with COND=LE, then COND=GT -> BR_ACK one cycle after each acceptance, BR_TAKEN=1 then 0; requests spaced 2 cycles apart.
- FLAGS_VALID=0, BR_REQ COND=EQ, CMP_VALID EQ=1 three cycles later -> BR_ACK on the following cycle, BR_TAKEN=1, TIMED_OUT=0.
- FLAGS_VALID=0, BR_REQ COND=NE, no CMP_VALID, TIMEOUT=15 -> BR_ACK 16 cycles after acceptance with BR_TAKEN=0, TIMED_OUT=1; COND=ALWAYS with no flags -> BR_TAKEN=1 after 1 cycle.
- CMP_VALID with EQ=1 and GT=1 -> ERR=1 (sticky), FLAGS unchanged; CLR_FLAGS plus legal CMP_VALID in the same cycle -> FLAGS_VALID=1.
- BR_REQ COND=GT with same-cycle CMP_VALID GT=1 while stored flags are EQ -> BR_TAKEN=1 (forwarding); RST during RESP -> BR_ACK drops immediately.

Source files
------------

// File: rtl/cond_flag_unit_pkg.sv
// Shared definitions for the condition-flag unit: condition codes, FSM states,
// flag bit positions and small helpers.
package cond_flag_unit_pkg;

  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_NE     = 3'b010;
  localparam logic [2:0] COND_LT     = 3'b011;
  localparam logic [2:0] COND_GE     = 3'b100;
  localparam logic [2:0] COND_GT     = 3'b101;
  localparam logic [2:0] COND_LE     = 3'b110;
  localparam logic [2:0] COND_NEVER  = 3'b111;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FLAGS = 2'd1,
    RESP       = 2'd2
  } state_t;

  localparam int unsigned FLAG_EQ = 0;
  localparam int unsigned FLAG_LT = 1;
  localparam int unsigned FLAG_GT = 2;

  function automatic logic is_one_hot(input logic [2:0] f);
    return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
  endfunction

  function automatic logic cond_needs_flags(input logic [2:0] c);
    return !((c == COND_ALWAYS) || (c == COND_NEVER));
  endfunction

endpackage

// File: rtl/cond_flag_unit_cond_eval.sv
// Combinational branch-condition evaluator over a {GT,LT,EQ} flag set.
module cond_eval
  import cond_flag_unit_pkg::*;
(
  input  logic [2:0] flags,
  input  logic [2:0] cond,
  output logic       taken
);

  logic eq;
  logic lt;
  logic gt;

  assign eq = flags[FLAG_EQ];
  assign lt = flags[FLAG_LT];
  assign gt = flags[FLAG_GT];

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      COND_ALWAYS: taken = 1'b1;
      COND_EQ:     taken = eq;
      COND_NE:     taken = ~eq;
      COND_LT:     taken = lt;
      COND_GE:     taken = gt | eq;
      COND_GT:     taken = gt;
      COND_LE:     taken = lt | eq;
      COND_NEVER:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Condition-flag register plus branch-resolution FSM: latches comparator results and
// answers REQ/ACK branch queries, stalling on missing flags with an optional timeout.
module cond_flag_unit
  import cond_flag_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CW      = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CMP_VALID,
  input  logic          EQ,
  input  logic          LT,
  input  logic          GT,
  input  logic          CLR_FLAGS,
  input  logic          BR_REQ,
  input  logic [CW-1:0] BR_COND,
  output logic          BR_ACK,
  output logic          BR_TAKEN,
  output logic [2:0]    FLAGS,
  output logic          FLAGS_VALID,
  output logic          TIMED_OUT,
  output logic          ERR
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [2:0]       in_flags;
  logic             in_legal;
  logic             cmp_legal;
  logic             cmp_bad;

  logic [2:0]       flags_q;
  logic             flags_valid_q;
  logic             err_q;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CW-1:0]    cond_q;
  logic             ack_q;
  logic             taken_q;
  logic             timed_out_q;

  logic [2:0]       eval_flags;
  logic [CW-1:0]    eval_cond;
  logic             eval_taken;
  logic             flags_ready;
  logic             timeout_hit;

  assign in_flags  = {GT, LT, EQ};
  assign in_legal  = is_one_hot(in_flags);
  assign cmp_legal = CMP_VALID & in_legal;
  assign cmp_bad   = CMP_VALID & ~in_legal;

  // Same-cycle legal compare result forwards past the stored flags.
  assign eval_flags = cmp_legal ? in_flags : flags_q;
  assign eval_cond  = (state_q == IDLE) ? BR_COND : cond_q;

  cond_eval u_cond_eval (
    .flags (eval_flags),
    .cond  (eval_cond),
    .taken (eval_taken)
  );

  assign flags_ready = ~cond_needs_flags(BR_COND) | flags_valid_q | cmp_legal;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      flags_q       <= 3'b000;
      flags_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      if (cmp_legal) begin
        flags_q       <= in_flags;
        flags_valid_q <= 1'b1;
      end else if (CLR_FLAGS) begin
        flags_valid_q <= 1'b0;
      end
      if (cmp_bad) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cond_q      <= '0;
      ack_q       <= 1'b0;
      taken_q     <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      ack_q       <= 1'b0;
      taken_q     <= 1'b0;
      timed_out_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (BR_REQ) begin
            cond_q <= BR_COND;
            if (flags_ready) begin
              state_q <= RESP;
              ack_q   <= 1'b1;
              taken_q <= eval_taken;
            end else begin
              state_q <= WAIT_FLAGS;
              cnt_q   <= '0;
            end
          end
        end
        WAIT_FLAGS: begin
          if (cmp_legal) begin
            state_q <= RESP;
            ack_q   <= 1'b1;
            taken_q <= eval_taken;
          end else if (timeout_hit) begin
            state_q     <= RESP;
            ack_q       <= 1'b1;
            timed_out_q <= 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BR_ACK      = ack_q;
  assign BR_TAKEN    = taken_q;
  assign TIMED_OUT   = timed_out_q;
  assign FLAGS       = flags_q;
  assign FLAGS_VALID = flags_valid_q;
  assign ERR         = err_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit: flag capture, branch resolution, waiting,
// timeout, error flagging, forwarding and asynchronous reset.
module tb_cond_flag_unit;

  logic       CLK;
  logic       RST;
  logic       CMP_VALID;
  logic       EQ;
  logic       LT;
  logic       GT;
  logic       CLR_FLAGS;
  logic       BR_REQ;
  logic [2:0] BR_COND;
  logic       BR_ACK;
  logic       BR_TAKEN;
  logic [2:0] FLAGS;
  logic       FLAGS_VALID;
  logic       TIMED_OUT;
  logic       ERR;

  int n_tests = 0;
  int n_fail  = 0;

  cond_flag_unit #(
    .TIMEOUT (15),
    .CW      (3)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .CMP_VALID   (CMP_VALID),
    .EQ          (EQ),
    .LT          (LT),
    .GT          (GT),
    .CLR_FLAGS   (CLR_FLAGS),
    .BR_REQ      (BR_REQ),
    .BR_COND     (BR_COND),
    .BR_ACK      (BR_ACK),
    .BR_TAKEN    (BR_TAKEN),
    .FLAGS       (FLAGS),
    .FLAGS_VALID (FLAGS_VALID),
    .TIMED_OUT   (TIMED_OUT),
    .ERR         (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmp(input logic gt, input logic lt, input logic eq);
    CMP_VALID = 1'b1;
    GT = gt;
    LT = lt;
    EQ = eq;
  endtask

  initial begin
    RST = 1'b1; CMP_VALID = 0; EQ = 0; LT = 0; GT = 0;
    CLR_FLAGS = 0; BR_REQ = 0; BR_COND = 3'b000;
    tick();
    tick();
    RST = 1'b0;

    // Load EQ, then reset mid-cycle: everything clears without a clock edge.
    cmp(0, 0, 1);
    tick();
    CMP_VALID = 0;
    chk("pre_rst_flags", {1'b0, FLAGS}, 4'h1);
    #3 RST = 1'b1;
    #1;
    chk("rst_flags", {1'b0, FLAGS}, 4'h0);
    chk("rst_outs", {BR_ACK, BR_TAKEN, FLAGS_VALID, TIMED_OUT}, 4'h0);
    chk("rst_err", {3'b0, ERR}, 4'h0);
    RST = 1'b0;
    cmp(0, 0, 1);
    tick();
    CMP_VALID = 0;
    chk("cap_eq_flags", {1'b0, FLAGS}, 4'h1);
    chk("cap_eq_valid", {3'b0, FLAGS_VALID}, 4'h1);

    // Store LT; LE then GT back-to-back (held request, accepted every 2 cycles).
    cmp(0, 1, 0);
    tick();
    CMP_VALID = 0;
    chk("cap_lt_flags", {1'b0, FLAGS}, 4'h2);
    BR_REQ = 1; BR_COND = 3'b110;
    tick();
    chk("le_ack_taken_to", {1'b0, BR_ACK, BR_TAKEN, TIMED_OUT}, 4'h6);
    BR_COND = 3'b101;
    tick();
    chk("gap_ack", {3'b0, BR_ACK}, 4'h0);
    tick();
    chk("gt_ack_taken_to", {1'b0, BR_ACK, BR_TAKEN, TIMED_OUT}, 4'h4);
    BR_REQ = 0;
    tick();
    chk("gt_ack_drop", {3'b0, BR_ACK}, 4'h0);

    // Invalidate, request EQ, deliver EQ three cycles after the request cycle.
    CLR_FLAGS = 1;
    tick();
    CLR_FLAGS = 0;
    chk("clr_valid", {3'b0, FLAGS_VALID}, 4'h0);
    chk("clr_keeps_flags", {1'b0, FLAGS}, 4'h2);
    BR_REQ = 1; BR_COND = 3'b001;
    tick();
    chk("wait1_ack", {3'b0, BR_ACK}, 4'h0);
    BR_COND = 3'b111;  // ignored while waiting
    tick();
    chk("wait2_ack", {3'b0, BR_ACK}, 4'h0);
    tick();
    chk("wait3_ack", {3'b0, BR_ACK}, 4'h0);
    cmp(0, 0, 1);
    tick();
    CMP_VALID = 0;
    chk("late_eq_resp", {1'b0, BR_ACK, BR_TAKEN, TIMED_OUT}, 4'h6);
    chk("late_eq_valid", {FLAGS_VALID, FLAGS}, 4'h9);
    BR_REQ = 0;
    tick();

    // Timeout: NE with no flags answers in the 16th cycle after the request cycle.
    CLR_FLAGS = 1;
    tick();
    CLR_FLAGS = 0;
    BR_REQ = 1; BR_COND = 3'b010;
    for (int i = 0; i < 15; i++) tick();
    chk("to_early_ack", {3'b0, BR_ACK}, 4'h0);
    tick();
    chk("to_resp", {1'b0, BR_ACK, BR_TAKEN, TIMED_OUT}, 4'h5);
    BR_REQ = 0;
    tick();
    chk("to_drop", {2'b0, BR_ACK, TIMED_OUT}, 4'h0);
    BR_REQ = 1; BR_COND = 3'b000;
    tick();
    chk("always_resp", {1'b0, BR_ACK, BR_TAKEN, TIMED_OUT}, 4'h6);
    BR_REQ = 0;
    tick();

    // Illegal flag set: sticky ERR, flags kept, and it cannot release a wait.
    BR_REQ = 1; BR_COND = 3'b001;
    cmp(1, 0, 1);
    tick();
    CMP_VALID = 0;
    chk("bad_err", {3'b0, ERR}, 4'h1);
    chk("bad_flags", {FLAGS_VALID, FLAGS}, 4'h1);
    chk("bad_no_ack", {3'b0, BR_ACK}, 4'h0);
    tick();
    chk("err_sticky", {3'b0, ERR}, 4'h1);
    chk("bad_wait_ack", {3'b0, BR_ACK}, 4'h0);
    CLR_FLAGS = 1;
    cmp(0, 1, 0);
    tick();
    CLR_FLAGS = 0; CMP_VALID = 0;
    chk("clr_cmp_valid", {FLAGS_VALID, FLAGS}, 4'hA);
    chk("clr_cmp_resp", {1'b0, BR_ACK, BR_TAKEN, TIMED_OUT}, 4'h4);
    BR_REQ = 0;
    tick();

    // Forwarding: stored EQ, same-cycle GT with COND=GT; then reset during RESP.
    cmp(0, 0, 1);
    tick();
    chk("fwd_stored", {1'b0, FLAGS}, 4'h1);
    BR_REQ = 1; BR_COND = 3'b101;
    cmp(1, 0, 0);
    tick();
    CMP_VALID = 0;
    chk("fwd_resp", {1'b0, BR_ACK, BR_TAKEN, TIMED_OUT}, 4'h6);
    #2 RST = 1'b1;
    #1;
    chk("rst_resp_ack", {2'b0, BR_ACK, BR_TAKEN}, 4'h0);
    chk("rst_resp_state", {ERR, FLAGS}, 4'h0);
    BR_REQ = 0;
    RST = 1'b0;
    tick();
    chk("rst_dropped", {3'b0, BR_ACK}, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
